// File: rtl/ctrl_pkg.sv
// Shared opcode/funct codes, control-field encodings, FSM states and the
// decoded control word used by the multicycle controller.
package ctrl_pkg;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_LW    = 4'b1010;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_ATYPE = 4'b1111;

  localparam logic [1:0] FN_ALU = 2'b00;
  localparam logic [1:0] FN_MUL = 2'b01;
  localparam logic [1:0] FN_DIV = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_RD    = 2'b01;
  localparam logic [1:0] RW_RD_R0 = 2'b10;

  localparam logic [1:0] JB_NONE   = 2'b00;
  localparam logic [1:0] JB_BRANCH = 2'b01;
  localparam logic [1:0] JB_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MDWAIT,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic       alu_src;
    logic       alu_b_type;
    logic       zero_ext;
    logic [1:0] alu_ctrl;
    logic [1:0] jump_branch;
    logic       is_lw;
    logic       is_sw;
    logic       is_muldiv;
    logic       is_halt;
    logic       legal;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decode into a control word plus legal flag.
// Opcodes wider than 4 bits compare against the zero-extended table.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W  = 2
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [FUNCT_W-1:0]  i_funct,
  output ctrl_word_t          o_ctrl
);

  always_comb begin
    o_ctrl             = '0;
    o_ctrl.alu_ctrl    = ALU_ADD;
    o_ctrl.jump_branch = JB_NONE;
    o_ctrl.legal       = 1'b1;
    case (i_opcode)
      OPCODE_W'(OP_ATYPE): begin
        o_ctrl.alu_b_type = 1'b1;
        case (i_funct)
          FUNCT_W'(FN_MUL), FUNCT_W'(FN_DIV): o_ctrl.is_muldiv = 1'b1;
          FUNCT_W'(FN_ALU):                   o_ctrl.is_muldiv = 1'b0;
          default:                            o_ctrl.is_muldiv = 1'b0;
        endcase
      end
      OPCODE_W'(OP_ANDI): begin
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.zero_ext = 1'b1;
        o_ctrl.alu_ctrl = ALU_AND;
      end
      OPCODE_W'(OP_ORI): begin
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.zero_ext = 1'b1;
        o_ctrl.alu_ctrl = ALU_OR;
      end
      OPCODE_W'(OP_LW): begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.is_lw   = 1'b1;
      end
      OPCODE_W'(OP_SW): begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.is_sw   = 1'b1;
      end
      OPCODE_W'(OP_BLT), OPCODE_W'(OP_BGT), OPCODE_W'(OP_BEQ): begin
        o_ctrl.alu_ctrl    = ALU_SUB;
        o_ctrl.jump_branch = JB_BRANCH;
      end
      OPCODE_W'(OP_JMP):  o_ctrl.jump_branch = JB_JUMP;
      OPCODE_W'(OP_HALT): o_ctrl.is_halt     = 1'b1;
      default:            o_ctrl.legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FSM controller: FETCH/DECODE/EXEC/MDWAIT/MEM/WB/HALTED.
// Define CTRL_MDDONE_EN to add the mdDone early-exit input for MDWAIT.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 4,
  parameter int FUNCT_W       = 2,
  parameter int MULDIV_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  multiDiv,
  input  logic                memReady,
`ifdef CTRL_MDDONE_EN
  input  logic                mdDone,
`endif
  output logic                pcWrite,
  output logic                irWrite,
  output logic                aluSrc,
  output logic                aluBType,
  output logic                zeroExtendFlag,
  output logic [1:0]          aluControl,
  output logic                memRead,
  output logic                memWrite,
  output logic                memToReg,
  output logic [1:0]          regWrite,
  output logic [1:0]          jumpBranch,
  output logic                mdStart,
  output logic                busy,
  output logic                halted,
  output logic                illegalOp
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_next;
  logic [OPCODE_W-1:0] r_opcode;
  logic [FUNCT_W-1:0]  r_funct;
  logic [OPCODE_W-1:0] w_dec_op;
  logic [FUNCT_W-1:0]  w_dec_fn;
  logic                w_md_done;
  ctrl_word_t          w_ctrl;

`ifdef CTRL_MDDONE_EN
  assign w_md_done = mdDone;
`else
  assign w_md_done = 1'b0;
`endif

  // DECODE looks at the live instruction; every later state uses the latched copy.
  assign w_dec_op = (r_state == S_DECODE) ? opcode   : r_opcode;
  assign w_dec_fn = (r_state == S_DECODE) ? multiDiv : r_funct;

  ctrl_decode #(
    .OPCODE_W (OPCODE_W),
    .FUNCT_W  (FUNCT_W)
  ) u_decode (
    .i_opcode (w_dec_op),
    .i_funct  (w_dec_fn),
    .o_ctrl   (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_count  <= '0;
      r_opcode <= '0;
      r_funct  <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
        r_funct  <= multiDiv;
      end
    end
  end

  // Outputs are forced low for the whole reset interval, FETCH included.
  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    pcWrite        = 1'b0;
    irWrite        = 1'b0;
    aluSrc         = 1'b0;
    aluBType       = 1'b0;
    zeroExtendFlag = 1'b0;
    aluControl     = ALU_ADD;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    memToReg       = 1'b0;
    regWrite       = RW_NONE;
    jumpBranch     = JB_NONE;
    mdStart        = 1'b0;
    busy           = 1'b0;
    halted         = 1'b0;
    illegalOp      = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          irWrite      = 1'b1;
          pcWrite      = 1'b1;
          w_state_next = S_DECODE;
        end
        S_DECODE: begin
          if (!w_ctrl.legal) begin
            illegalOp    = 1'b1;
            w_state_next = S_FETCH;
          end else if (w_ctrl.is_halt) begin
            w_state_next = S_HALTED;
          end else begin
            w_state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          aluSrc         = w_ctrl.alu_src;
          aluBType       = w_ctrl.alu_b_type;
          zeroExtendFlag = w_ctrl.zero_ext;
          aluControl     = w_ctrl.alu_ctrl;
          jumpBranch     = w_ctrl.jump_branch;
          if (w_ctrl.jump_branch != JB_NONE) begin
            pcWrite      = 1'b1;
            w_state_next = S_FETCH;
          end else if (w_ctrl.is_muldiv) begin
            mdStart      = 1'b1;
            w_count_next = CNT_LOAD;
            w_state_next = S_MDWAIT;
          end else if (w_ctrl.is_lw || w_ctrl.is_sw) begin
            w_state_next = S_MEM;
          end else begin
            w_state_next = S_WB;
          end
        end
        S_MDWAIT: begin
          busy = 1'b1;
          if (w_md_done || r_count <= CNT_ONE) begin
            w_count_next = '0;
            w_state_next = S_WB;
          end else begin
            w_count_next = r_count - CNT_ONE;
          end
        end
        S_MEM: begin
          memRead  = w_ctrl.is_lw;
          memWrite = w_ctrl.is_sw;
          busy     = !memReady;
          if (memReady) w_state_next = w_ctrl.is_lw ? S_WB : S_FETCH;
        end
        S_WB: begin
          regWrite     = w_ctrl.is_muldiv ? RW_RD_R0 : RW_RD;
          memToReg     = w_ctrl.is_lw;
          w_state_next = S_FETCH;
        end
        S_HALTED: halted = 1'b1;
        default:  w_state_next = S_FETCH;
      endcase
    end
  end

endmodule
